// File: rtl/mc_controller_v2.sv
//------------------------------------------------------------------------------
// Module   : mc_controller_v2
// Brief    : Multicycle RV32I control unit with branch evaluation, memory
//            wait states, illegal-opcode trap and cycle/instret counters.
// Revision : 2.0
//------------------------------------------------------------------------------
`default_nettype none

module mc_controller_v2 #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit TRAP_EN     = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic [1:0]       sel_alu_src_a,
  output logic [1:0]       sel_alu_src_b,
  output logic [1:0]       sel_result,
  output logic             sel_mem_addr,
  output logic             we_mem,
  output logic             we_pc,
  output logic             we_ir,
  output logic             we_rf,
  output logic [2:0]       sel_ext,
  output logic [3:0]       alu_control,
  output logic             trap,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_ADR = 4'd11,
    S_JALR_PC  = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_r     = 7'b0110011;
  localparam logic [6:0] c_op_i     = 7'b0010011;
  localparam logic [6:0] c_op_br    = 7'b1100011;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_jalr  = 7'b1100111;
  localparam logic [6:0] c_op_lui   = 7'b0110111;
  localparam logic [6:0] c_op_auipc = 7'b0010111;

  localparam logic [3:0] c_alu_add  = 4'b0000;
  localparam logic [3:0] c_alu_sub  = 4'b0001;
  localparam logic [3:0] c_alu_and  = 4'b0010;
  localparam logic [3:0] c_alu_or   = 4'b0011;
  localparam logic [3:0] c_alu_xor  = 4'b0100;
  localparam logic [3:0] c_alu_slt  = 4'b0101;
  localparam logic [3:0] c_alu_sltu = 4'b0110;
  localparam logic [3:0] c_alu_sll  = 4'b0111;
  localparam logic [3:0] c_alu_srl  = 4'b1000;
  localparam logic [3:0] c_alu_sra  = 4'b1001;
  localparam logic [3:0] c_alu_passb = 4'b1010;

  localparam logic [1:0] c_a_pc    = 2'b00;
  localparam logic [1:0] c_a_oldpc = 2'b01;
  localparam logic [1:0] c_a_rs1   = 2'b10;
  localparam logic [1:0] c_b_rs2   = 2'b00;
  localparam logic [1:0] c_b_imm   = 2'b01;
  localparam logic [1:0] c_b_four  = 2'b10;
  localparam logic [1:0] c_res_aluout = 2'b00;
  localparam logic [1:0] c_res_data   = 2'b01;
  localparam logic [1:0] c_res_alu    = 2'b10;

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t     r_state;
  state_t     w_next_state;
  logic       w_mem_ready;
  logic       w_taken;
  logic       w_bad_branch;
  logic [3:0] w_alu_dec;
  logic [2:0] w_ext;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  assign w_mem_ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Branch condition from the ALU flags of rs1 - rs2.
  always_comb begin
    w_taken      = 1'b0;
    w_bad_branch = 1'b0;
    case (funct3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      3'b100:  w_taken = lt;
      3'b101:  w_taken = ~lt;
      3'b110:  w_taken = ltu;
      3'b111:  w_taken = ~ltu;
      default: w_bad_branch = 1'b1;
    endcase
  end

  always_comb begin
    w_alu_dec = c_alu_add;
    case (funct3)
      3'b000:  w_alu_dec = (r_state == S_EXEC_R && funct7b5) ? c_alu_sub : c_alu_add;
      3'b001:  w_alu_dec = c_alu_sll;
      3'b010:  w_alu_dec = c_alu_slt;
      3'b011:  w_alu_dec = c_alu_sltu;
      3'b100:  w_alu_dec = c_alu_xor;
      3'b101:  w_alu_dec = funct7b5 ? c_alu_sra : c_alu_srl;
      3'b110:  w_alu_dec = c_alu_or;
      default: w_alu_dec = c_alu_and;
    endcase
  end

  // Immediate format follows the held instruction in every state.
  always_comb begin
    w_ext = 3'b000;
    case (op)
      c_op_store:           w_ext = 3'b001;
      c_op_br:              w_ext = 3'b010;
      c_op_jal:             w_ext = 3'b011;
      c_op_lui, c_op_auipc: w_ext = 3'b100;
      default:              w_ext = 3'b000;
    endcase
  end

  always_comb begin
    w_next_state  = r_state;
    sel_alu_src_a = c_a_pc;
    sel_alu_src_b = c_b_rs2;
    sel_result    = c_res_aluout;
    sel_mem_addr  = 1'b0;
    we_mem        = 1'b0;
    we_pc         = 1'b0;
    we_ir         = 1'b0;
    we_rf         = 1'b0;
    sel_ext       = w_ext;
    alu_control   = c_alu_add;
    trap          = 1'b0;

    case (r_state)
      S_FETCH: begin
        sel_alu_src_b = c_b_four;
        sel_result    = c_res_alu;
        we_ir         = w_mem_ready;
        we_pc         = w_mem_ready;
        if (w_mem_ready) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        sel_alu_src_a = c_a_oldpc;
        sel_alu_src_b = c_b_imm;
        case (op)
          c_op_load, c_op_store: w_next_state = S_MEMADR;
          c_op_r:                w_next_state = S_EXEC_R;
          c_op_i:                w_next_state = S_EXEC_I;
          c_op_br:               w_next_state = S_BRANCH;
          c_op_jal:              w_next_state = S_JAL;
          c_op_jalr:             w_next_state = S_JALR_ADR;
          c_op_lui:              w_next_state = S_LUI;
          c_op_auipc:            w_next_state = S_AUIPC;
          default:               w_next_state = TRAP_EN ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        sel_alu_src_a = c_a_rs1;
        sel_alu_src_b = c_b_imm;
        w_next_state  = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        sel_mem_addr = 1'b1;
        if (w_mem_ready) w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        sel_result   = c_res_data;
        we_rf        = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        // Write strobe is held for the whole access, including the ready cycle.
        sel_mem_addr = 1'b1;
        we_mem       = 1'b1;
        if (w_mem_ready) w_next_state = S_FETCH;
      end
      S_EXEC_R: begin
        sel_alu_src_a = c_a_rs1;
        sel_alu_src_b = c_b_rs2;
        alu_control   = w_alu_dec;
        w_next_state  = S_ALUWB;
      end
      S_EXEC_I: begin
        sel_alu_src_a = c_a_rs1;
        sel_alu_src_b = c_b_imm;
        alu_control   = w_alu_dec;
        w_next_state  = S_ALUWB;
      end
      S_ALUWB: begin
        we_rf        = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        sel_alu_src_a = c_a_rs1;
        sel_alu_src_b = c_b_rs2;
        alu_control   = c_alu_sub;
        we_pc         = w_taken;
        w_next_state  = (TRAP_EN && w_bad_branch) ? S_TRAP : S_FETCH;
      end
      S_JAL: begin
        sel_alu_src_a = c_a_oldpc;
        sel_alu_src_b = c_b_four;
        we_pc         = 1'b1;
        w_next_state  = S_ALUWB;
      end
      S_JALR_ADR: begin
        sel_alu_src_a = c_a_rs1;
        sel_alu_src_b = c_b_imm;
        w_next_state  = S_JALR_PC;
      end
      S_JALR_PC: begin
        sel_alu_src_a = c_a_oldpc;
        sel_alu_src_b = c_b_four;
        we_pc         = 1'b1;
        w_next_state  = S_ALUWB;
      end
      S_LUI: begin
        sel_alu_src_b = c_b_imm;
        alu_control   = c_alu_passb;
        w_next_state  = S_ALUWB;
      end
      S_AUIPC: begin
        sel_alu_src_a = c_a_oldpc;
        sel_alu_src_b = c_b_imm;
        w_next_state  = S_ALUWB;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: w_next_state = S_FETCH;
    endcase

    // Held in reset: every select and enable is forced low.
    if (!rst) begin
      sel_alu_src_a = 2'b00;
      sel_alu_src_b = 2'b00;
      sel_result    = 2'b00;
      sel_mem_addr  = 1'b0;
      we_mem        = 1'b0;
      we_pc         = 1'b0;
      we_ir         = 1'b0;
      we_rf         = 1'b0;
      sel_ext       = 3'b000;
      alu_control   = 4'b0000;
      trap          = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_state != S_TRAP) begin
        r_cycle_cnt <= r_cycle_cnt + c_cnt_one;
      end
      if (r_state != S_FETCH && w_next_state == S_FETCH) begin
        r_instret_cnt <= r_instret_cnt + c_cnt_one;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mc_controller_v2.sv
//------------------------------------------------------------------------------
// Module   : tb_mc_controller_v2
// Brief    : Directed self-checking bench for mc_controller_v2.
// Revision : 2.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mc_controller_v2;

  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst, rst2;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, zero, lt, ltu, mem_ready;

  logic [1:0] a1, b1, res1, a2, b2, res2;
  logic madr1, wmem1, wpc1, wir1, wrf1, trap1;
  logic madr2, wmem2, wpc2, wir2, wrf2, trap2;
  logic [2:0] ext1, ext2;
  logic [3:0] alu1, alu2;
  logic [31:0] cyc1, ret1, cyc2, ret2;
  logic [15:0] obs1, obs2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_controller_v2 #(.MEM_WAIT_EN(1'b1), .TRAP_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .sel_alu_src_a(a1), .sel_alu_src_b(b1), .sel_result(res1),
    .sel_mem_addr(madr1), .we_mem(wmem1), .we_pc(wpc1), .we_ir(wir1),
    .we_rf(wrf1), .sel_ext(ext1), .alu_control(alu1), .trap(trap1),
    .cycle_cnt(cyc1), .instret_cnt(ret1)
  );

  mc_controller_v2 #(.MEM_WAIT_EN(1'b0), .TRAP_EN(1'b0), .CNT_W(32)) dut_nt (
    .clk(clk), .rst(rst2), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .sel_alu_src_a(a2), .sel_alu_src_b(b2), .sel_result(res2),
    .sel_mem_addr(madr2), .we_mem(wmem2), .we_pc(wpc2), .we_ir(wir2),
    .we_rf(wrf2), .sel_ext(ext2), .alu_control(alu2), .trap(trap2),
    .cycle_cnt(cyc2), .instret_cnt(ret2)
  );

  assign obs1 = {a1, b1, res1, madr1, wmem1, wpc1, wir1, wrf1, alu1, trap1};
  assign obs2 = {a2, b2, res2, madr2, wmem2, wpc2, wir2, wrf2, alu2, trap2};

  function automatic logic [15:0] ctl(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] res, input logic madr,
                                      input logic wmem, input logic wpc,
                                      input logic wir, input logic wrf,
                                      input logic [3:0] alu, input logic trp);
    return {a, b, res, madr, wmem, wpc, wir, wrf, alu, trp};
  endfunction

  function automatic logic [15:0] fetch(input logic rdy);
    return ctl(2'b00, 2'b10, 2'b10, 1'b0, 1'b0, rdy, rdy, 1'b0, 4'h0, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; rst2 = 1'b0;
    op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;

    // Reset held
    step(); step();
    chk("rst_ctl", {16'h0, obs1}, 32'h0);
    chk("rst_ext", {29'h0, ext1}, 32'h0);
    chk("rst_cyc", cyc1, 32'd0);
    chk("rst_ret", ret1, 32'd0);

    // Release, ADD R-type
    rst = 1'b1; #1;
    chk("fetch0", {16'h0, obs1}, {16'h0, fetch(1'b1)});
    chk("fetch0_cyc", cyc1, 32'd0);
    step();
    chk("dec_r", {16'h0, obs1}, {16'h0, ctl(2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0)});
    chk("dec_cyc", cyc1, 32'd1);
    step();
    chk("exec_add", {16'h0, obs1}, {16'h0, ctl(2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0)});
    step();
    chk("aluwb", {16'h0, obs1}, {16'h0, ctl(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 4'h0, 0)});
    chk("aluwb_ret", ret1, 32'd0);
    step();
    chk("add_ret", ret1, 32'd1);
    chk("add_cyc", cyc1, 32'd4);

    // SUB R-type
    funct7b5 = 1'b1;
    step(); step();
    chk("exec_sub", {16'h0, obs1}, {16'h0, ctl(2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h1, 0)});
    step(); step();
    chk("sub_ret", ret1, 32'd2);

    // SRAI
    op = OP_I; funct3 = 3'b101; funct7b5 = 1'b1;
    step(); step();
    chk("exec_srai", {16'h0, obs1}, {16'h0, ctl(2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'h9, 0)});
    step(); step();
    chk("srai_cyc", cyc1, 32'd12);

    // BLT taken / not taken
    op = OP_B; funct3 = 3'b100; funct7b5 = 1'b0; lt = 1'b1;
    step();
    chk("ext_b", {29'h0, ext1}, 32'd2);
    step();
    chk("blt_taken", {16'h0, obs1}, {16'h0, ctl(2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0, 4'h1, 0)});
    lt = 1'b0; #1;
    chk("blt_not", {16'h0, obs1}, {16'h0, ctl(2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h1, 0)});
    step();
    chk("blt_ret", ret1, 32'd4);
    chk("blt_cyc", cyc1, 32'd15);

    // BGEU with ltu=0
    funct3 = 3'b111; ltu = 1'b0;
    step(); step();
    chk("bgeu_wpc", {31'h0, wpc1}, 32'd1);
    ltu = 1'b1; #1;
    chk("bgeu_nwpc", {31'h0, wpc1}, 32'd0);
    step();

    // LW with 3 wait cycles
    op = OP_L; funct3 = 3'b010;
    step(); step();
    chk("memadr", {16'h0, obs1}, {16'h0, ctl(2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0)});
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("memread_wait", {16'h0, obs1}, {16'h0, ctl(2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 4'h0, 0)});
      step();
    end
    mem_ready = 1'b1; #1;
    chk("memread_rdy", {16'h0, obs1}, {16'h0, ctl(2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 4'h0, 0)});
    step();
    chk("memwb", {16'h0, obs1}, {16'h0, ctl(2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 1, 4'h0, 0)});
    step();
    chk("lw_cyc", cyc1, 32'd26);
    chk("lw_ret", ret1, 32'd6);

    // FETCH stall
    mem_ready = 1'b0; #1;
    chk("fetch_stall", {16'h0, obs1}, {16'h0, fetch(1'b0)});
    step();
    chk("fetch_hold", {16'h0, obs1}, {16'h0, fetch(1'b0)});
    mem_ready = 1'b1;

    // SW with 2 wait cycles
    op = OP_S;
    step();
    chk("ext_s", {29'h0, ext1}, 32'd1);
    step();
    mem_ready = 1'b0;
    step();
    chk("sw_we1", {16'h0, obs1}, {16'h0, ctl(2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 4'h0, 0)});
    step();
    chk("sw_we2", {31'h0, wmem1}, 32'd1);
    step();
    mem_ready = 1'b1; #1;
    chk("sw_we3", {31'h0, wmem1}, 32'd1);
    step();
    chk("sw_fetch", {16'h0, obs1}, {16'h0, fetch(1'b1)});
    chk("sw_ret", ret1, 32'd7);
    chk("sw_cyc", cyc1, 32'd33);

    // JAL
    op = OP_JAL;
    step();
    chk("ext_j", {29'h0, ext1}, 32'd3);
    step();
    chk("jal", {16'h0, obs1}, {16'h0, ctl(2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 4'h0, 0)});
    step(); step();

    // JALR
    op = OP_JR;
    step(); step();
    chk("jalr_adr", {16'h0, obs1}, {16'h0, ctl(2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0)});
    step();
    chk("jalr_pc", {16'h0, obs1}, {16'h0, ctl(2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 4'h0, 0)});
    step(); step();
    chk("jalr_ret", ret1, 32'd9);

    // LUI
    op = OP_LUI;
    step();
    chk("ext_u", {29'h0, ext1}, 32'd4);
    step();
    chk("lui", {16'h0, obs1}, {16'h0, ctl(2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'hA, 0)});
    step(); step();

    // AUIPC
    op = OP_AUI;
    step(); step();
    chk("auipc", {16'h0, obs1}, {16'h0, ctl(2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0)});
    step(); step();
    chk("auipc_cyc", cyc1, 32'd50);
    chk("auipc_ret", ret1, 32'd11);

    // Illegal opcode -> TRAP
    op = OP_BAD;
    step(); step();
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      #1;
      chk("trap_ctl", {16'h0, obs1}, {16'h0, ctl(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h0, 1)});
      step();
    end
    chk("trap_cyc", cyc1, 32'd52);
    chk("trap_ret", ret1, 32'd11);

    // Reset out of TRAP, then reset in the middle of a store
    rst = 1'b0; mem_ready = 1'b1; #1;
    chk("trap_rst", {16'h0, obs1}, 32'h0);
    chk("trap_rst_cyc", cyc1, 32'd0);
    step();
    rst = 1'b1; op = OP_S;
    step(); step();
    mem_ready = 1'b0;
    step();
    chk("abort_pre", {31'h0, wmem1}, 32'd1);
    rst = 1'b0; #1;
    chk("abort_ctl", {16'h0, obs1}, 32'h0);
    step();
    chk("abort_hold", {16'h0, obs1}, 32'h0);
    chk("abort_ret", ret1, 32'd0);

    // No-trap, no-wait instance
    op = OP_BAD; mem_ready = 1'b0;
    rst2 = 1'b1; #1;
    chk("nt_fetch", {16'h0, obs2}, {16'h0, fetch(1'b1)});
    step(); step();
    chk("nt_bad_fetch", {16'h0, obs2}, {16'h0, fetch(1'b1)});
    chk("nt_bad_ret", ret2, 32'd1);
    chk("nt_bad_cyc", cyc2, 32'd2);
    op = OP_L;
    step(); step(); step();
    chk("nt_memread", {16'h0, obs2}, {16'h0, ctl(2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 4'h0, 0)});
    step();
    chk("nt_memwb", {16'h0, obs2}, {16'h0, ctl(2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 1, 4'h0, 0)});
    step();
    chk("nt_lw_ret", ret2, 32'd2);
    chk("nt_lw_cyc", cyc2, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_controller_v2.md
Name: mc_controller_v2

Overview:
Second-generation multicycle RV32I control unit. Sequences fetch/decode/execute/writeback and drives all datapath selects and write enables. Adds over the first generation:
- Full branch-condition evaluation for all six branches.
- JALR, LUI and AUIPC sequencing.
- Memory wait-state handshake and illegal-opcode trap.
- Cycle and retired-instruction counters.

Parameters:
MEM_WAIT_EN, 1, 1 = stall on mem_ready low; 0 = treat mem_ready as always 1
TRAP_EN, 1, 1 = unknown opcode enters TRAP; 0 = treated as NOP (back to FETCH)
CNT_W, 32, width of cycle_cnt and instret_cnt

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
op  input  7  instr[6:0]
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU result == 0
lt  input  1  signed A<B from ALU
ltu  input  1  unsigned A<B from ALU
mem_ready  input  1  memory access completes this cycle
sel_alu_src_a  output  2  00 PC, 01 oldPC, 10 rs1 reg
sel_alu_src_b  output  2  00 rs2 reg, 01 imm, 10 const 4
sel_result  output  2  00 ALUOut reg, 01 data reg, 10 ALU result
sel_mem_addr  output  1  0 PC, 1 result
we_mem, we_pc, we_ir, we_rf  output  1 each  write enables
sel_ext  output  3  000 I, 001 S, 010 B, 011 J, 100 U
alu_control  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 PASS_B
trap  output  1  high while in TRAP
cycle_cnt  output  CNT_W  cycles since reset
instret_cnt  output  CNT_W  retired instructions

Behaviour:
- Reset (rst=0, async):
  - State = FETCH; both counters = 0.
  - While held, all write enables = 0 and all selects = 0.
- After release, outputs are combinational from state plus inputs (Moore, except we_pc/we_ir/we_mem gated by mem_ready and branch flags).
- States and per-state outputs:
  - FETCH: sel_mem_addr=0, A=PC, B=4, ADD, sel_result=10. we_ir=we_pc=mem_ready. Stay while !mem_ready, else -> DECODE.
  - DECODE: A=oldPC, B=imm, ADD (branch/JAL target into ALUOut). sel_ext from op. Next state by op:
    - 0000011 -> MEMADR
    - 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR_ADR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - other -> TRAP (TRAP_EN=1) or FETCH (TRAP_EN=0, counts as retired)
  - MEMADR: A=rs1, B=imm, ADD. Next MEMREAD (op[5]=0) or MEMWRITE.
  - MEMREAD: sel_result=00, sel_mem_addr=1. Wait on mem_ready, then -> MEMWB.
  - MEMWB: sel_result=01, we_rf=1 -> FETCH.
  - MEMWRITE: sel_result=00, sel_mem_addr=1, we_mem=1 every cycle until mem_ready; completes -> FETCH.
  - EXEC_R: A=rs1, B=rs2. EXEC_I: A=rs1, B=imm. Both -> ALUWB.
    - ALU op from funct3: 000 ADD (SUB if R-type & funct7b5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7b5 (both formats), 110 OR, 111 AND.
  - ALUWB: sel_result=00, we_rf=1 -> FETCH.
  - BRANCH: A=rs1, B=rs2, SUB, sel_result=00. we_pc=taken -> FETCH. taken by funct3:
    - 000 zero
    - 001 !zero
    - 100 lt
    - 101 !lt
    - 110 ltu
    - 111 !ltu
    - 010/011: taken=0 (TRAP if TRAP_EN)
  - JAL: A=oldPC, B=4, ADD, sel_result=00, we_pc=1 -> ALUWB.
  - JALR_ADR: A=rs1, B=imm, ADD -> JALR_PC.
  - JALR_PC: A=oldPC, B=4, ADD, sel_result=00, we_pc=1 -> ALUWB. Target LSB clearing is done in the datapath.
  - LUI: B=imm(U), PASS_B -> ALUWB.
  - AUIPC: A=oldPC, B=imm(U), ADD -> ALUWB.
  - TRAP: all write enables 0, trap=1. Terminal until reset.
- Counters:
  - cycle_cnt increments every cycle out of reset; stops in TRAP.
  - instret_cnt increments on the transition into FETCH from any state except reset; not on trap.
  - Both wrap modulo 2^CNT_W silently.
- Wait states: when MEM_WAIT_EN=0, every access completes in one cycle.
- Reset mid-access (e.g. in MEMWRITE) aborts immediately; no further we_mem.

Test Plan:
- Reset: release rst with mem_ready=1 -> FETCH, we_ir=we_pc=1 in first cycle; counters 0 then cycle_cnt=1.
- ADD R-type (op 0110011, f3 000, f7b5 0): FETCH->DECODE->EXEC_R->ALUWB (alu_control 0000, we_rf=1); instret_cnt+1 after 4 cycles. f7b5=1 gives 0001.
- BLT (f3 100) with lt=1 -> we_pc=1 in BRANCH. With lt=0 -> we_pc=0. BGEU with ltu=0 -> we_pc=1.
- LW with mem_ready low 3 cycles in MEMREAD -> state holds 3 cycles, MEMWB we_rf=1, sel_result=01; total 8 cycles.
- SW with mem_ready low 2 cycles -> we_mem high 3 consecutive cycles, then FETCH.
- Opcode 1111111 -> TRAP, trap=1, all enables 0 for 10 cycles, cycle_cnt frozen. Same with TRAP_EN=0 -> FETCH, instret_cnt+1.
